pll_reconfig_sequencer: RTL and testbench
=========================================

// Module: pll_reconfig_sequencer
// PURPOSE
//  Drives the Avalon-MM management port of an altera_pll_reconfig instance to retune a
//  running PLL (e.g. video/system clock change). Host loads a table of register writes,
//  pulses cfg_start; block writes mode, table entries and START, waits for PLL relock,
//  reports done/error. Sits between the core's config logic and the PLL reconfig IP.
// PARAMETERS
//  DEPTH         8        table entries (power of 2, 2..32)
//  LOCK_TIMEOUT  500000   refclk cycles to wait for relock before cfg_err
//  BUSY_TIMEOUT  4096     refclk cycles to wait for mgmt_waitrequest low before cfg_err
// PORTS
//  refclk           in   1   management clock (PLL reference clock domain)
//  rst              in   1   synchronous, active-high reset
//  tbl_we           in   1   table write strobe (ignored while cfg_busy)
//  tbl_idx          in   $clog2(DEPTH)  table entry index
//  tbl_addr         in   6   reconfig register address for the entry
//  tbl_data         in   32  reconfig register data for the entry
//  cfg_count        in   $clog2(DEPTH)+1  entries to send (0 = START only), sampled at cfg_start
//  cfg_start        in   1   one-cycle request (ignored while cfg_busy)
//  cfg_busy         out  1   sequence in progress
//  cfg_done         out  1   one-cycle pulse: sequence finished, PLL relocked
//  cfg_err          out  1   sticky until next accepted cfg_start: timeout occurred
//  mgmt_address     out  6   Avalon-MM address to reconfig IP
//  mgmt_write       out  1   Avalon-MM write
//  mgmt_writedata   out  32  Avalon-MM write data
//  mgmt_waitrequest in   1   Avalon-MM waitrequest
//  pll_locked       in   1   PLL locked (asynchronous)
// BEHAVIOUR
//  - Reset: all outputs 0; FSM IDLE; counters 0; table contents undefined (not cleared).
//  - pll_locked passes a 2-flop synchroniser; all uses below refer to synchronised lock.
//  - Avalon rule: mgmt_address/writedata held stable while mgmt_write=1 and waitrequest=1;
//    a write completes on the first cycle with mgmt_write=1 and waitrequest=0; mgmt_write
//    drops the cycle after completion. No reads issued.
//  - FSM: IDLE -> MODE -> WRITE -> START -> BUSY -> LOCK -> IDLE.
//    IDLE : cfg_start=1 -> latch cfg_count, clear cfg_err, cfg_busy=1, go MODE.
//    MODE : write addr 0x00 data 0 (waitrequest mode); on completion go WRITE (count>0) or START.
//    WRITE: write entry i (i=0..count-1) at tbl_addr[i]/tbl_data[i]; after last go START.
//    START: write addr 0x02 data 0; on completion go BUSY.
//    BUSY : wait waitrequest=0 with mgmt_write=0 for 1 cycle; >BUSY_TIMEOUT -> err path.
//    LOCK : wait synchronised lock=1; found -> cfg_done pulse, IDLE; >LOCK_TIMEOUT -> err.
//    err path: cfg_err=1, cfg_busy=0, no cfg_done, IDLE.
//  - Waitrequest stall during MODE/WRITE/START also counted against BUSY_TIMEOUT; counter
//    restarts at each new write.
//  - LOCK first waits for lock to read 0 or 16 cycles to elapse (whichever first), so a
//    stale pre-retune lock is not accepted.
//  - cfg_done and cfg_busy falling occur on the same edge; cfg_busy low one cycle before
//    a new cfg_start may be accepted (back-to-back start in done cycle is ignored).
//  - cfg_count > DEPTH saturates to DEPTH.
//  - rst mid-sequence: immediately to reset state, mgmt_write=0 next cycle; PLL left as is.
//  - tbl_we while busy is dropped (table stable during sequence).
// STRUCTURE
//  - Package pll_reconfig_pkg: state enum, register address constants (MODE=6'h00,
//    START=6'h02, N=6'h03, M=6'h04, C=6'h05, BW=6'h08, CP=6'h09).
//  - Sub-module sync2 (2-flop synchroniser) for pll_locked; table as DEPTH x 38 reg array.
// TESTING
//  - Load 3 entries (0x04/0x00000808, 0x03/0x00010000, 0x05/0x00020404), count=3, start ->
//    exactly writes 00/0, 04, 03, 05, 02/0 in order; done pulse after model relocks.
//  - Waitrequest held high 5 cycles on write 2 -> address/data stable, no duplicate write.
//  - Lock never returns -> cfg_err=1 at LOCK_TIMEOUT+small fixed latency, no cfg_done.
//  - count=0 -> only MODE and START writes, then done.
//  - rst asserted during WRITE -> next cycle all outputs 0; later start runs full sequence.
//  - cfg_start and tbl_we while busy -> ignored; table contents of running sequence unchanged.

Source files
------------

// File: rtl/pll_reconfig_pkg.sv
// pll_reconfig_pkg: sequencer states and altera_pll_reconfig register map
package pll_reconfig_pkg;
  typedef enum logic [2:0] {S_IDLE, S_MODE, S_WRITE, S_START, S_BUSY, S_LOCK} state_e;
  localparam logic [5:0] REG_MODE = 6'h00;
  localparam logic [5:0] REG_START = 6'h02;
  localparam logic [5:0] REG_N = 6'h03;
  localparam logic [5:0] REG_M = 6'h04;
  localparam logic [5:0] REG_C = 6'h05;
  localparam logic [5:0] REG_BW = 6'h08;
  localparam logic [5:0] REG_CP = 6'h09;
  localparam int STALE_CYCLES = 16;
endpackage

// File: rtl/pll_reconfig_sequencer_sync2.sv
// sync2: two-flop synchroniser for a single asynchronous level
module sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);
  logic m_q;
  always_ff @(posedge clk)
    {q_o, m_q} <= rst ? 2'b00 : {m_q, d_i};
endmodule

// File: rtl/pll_reconfig_sequencer.sv
// pll_reconfig_sequencer: replays a register table into altera_pll_reconfig and waits for relock
module pll_reconfig_sequencer
  import pll_reconfig_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int LOCK_TIMEOUT = 500000,
  parameter int BUSY_TIMEOUT = 4096,
  localparam int IW = $clog2(DEPTH),
  localparam int CW = IW + 1
) (
  input  logic          refclk,
  input  logic          rst,
  input  logic          tbl_we,
  input  logic [IW-1:0] tbl_idx,
  input  logic [5:0]    tbl_addr,
  input  logic [31:0]   tbl_data,
  input  logic [CW-1:0] cfg_count,
  input  logic          cfg_start,
  output logic          cfg_busy,
  output logic          cfg_done,
  output logic          cfg_err,
  output logic [5:0]    mgmt_address,
  output logic          mgmt_write,
  output logic [31:0]   mgmt_writedata,
  input  logic          mgmt_waitrequest,
  input  logic          pll_locked
);
  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, idx_q, idx_d, idx_nx, cnt_sat;
  logic [31:0]   tmr_q, tmr_d, data_q, data_d;
  logic [5:0]    addr_q, addr_d;
  logic          wr_q, wr_d, busy_q, busy_d, done_q, done_d, err_q, err_d, stale_q, stale_d;
  logic          lock_s, fail;
  logic [37:0]   tbl_q [DEPTH];
  logic [37:0]   ent;
  sync2 u_sync (.clk(refclk), .rst(rst), .d_i(pll_locked), .q_o(lock_s));
  always_ff @(posedge refclk)
    if (tbl_we && !busy_q) tbl_q[tbl_idx] <= {tbl_addr, tbl_data};
  assign ent = tbl_q[idx_q[IW-1:0]];
  assign idx_nx = idx_q + CW'(1);
  assign cnt_sat = cfg_count > CW'(DEPTH) ? CW'(DEPTH) : cfg_count;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    idx_d = idx_q;
    tmr_d = tmr_q;
    wr_d = wr_q;
    addr_d = addr_q;
    data_d = data_q;
    busy_d = busy_q;
    err_d = err_q;
    stale_d = stale_q;
    done_d = 1'b0;
    fail = 1'b0;
    case (state_q)
      S_IDLE: if (cfg_start && !done_q) begin
        state_d = S_MODE;
        cnt_d = cnt_sat;
        idx_d = '0;
        err_d = 1'b0;
        busy_d = 1'b1;
      end
      S_MODE, S_WRITE, S_START: if (!wr_q) begin
        wr_d = 1'b1;
        tmr_d = '0;
        addr_d = state_q == S_WRITE ? ent[37:32] : state_q == S_MODE ? REG_MODE : REG_START;
        data_d = state_q == S_WRITE ? ent[31:0] : '0;
      end else if (!mgmt_waitrequest) begin
        wr_d = 1'b0;
        tmr_d = '0;
        idx_d = state_q == S_WRITE ? idx_nx : idx_q;
        state_d = state_q == S_START ? S_BUSY :
                  (state_q == S_MODE ? cnt_q != '0 : idx_nx != cnt_q) ? S_WRITE : S_START;
      end else if (tmr_q >= 32'(BUSY_TIMEOUT)) begin
        fail = 1'b1;
      end else begin
        tmr_d = tmr_q + 32'd1;
      end
      S_BUSY: if (!mgmt_waitrequest) begin
        state_d = S_LOCK;
        tmr_d = '0;
        stale_d = 1'b0;
      end else if (tmr_q >= 32'(BUSY_TIMEOUT)) begin
        fail = 1'b1;
      end else begin
        tmr_d = tmr_q + 32'd1;
      end
      // a lock that never dropped after START is the old one; wait for a low or 16 cycles
      S_LOCK: if (stale_q && lock_s) begin
        state_d = S_IDLE;
        busy_d = 1'b0;
        done_d = 1'b1;
      end else if (tmr_q >= 32'(LOCK_TIMEOUT)) begin
        fail = 1'b1;
      end else begin
        tmr_d = tmr_q + 32'd1;
        stale_d = stale_q | !lock_s | (tmr_q == 32'(STALE_CYCLES - 1));
      end
      default: state_d = S_IDLE;
    endcase
    if (fail) begin
      state_d = S_IDLE;
      busy_d = 1'b0;
      err_d = 1'b1;
      wr_d = 1'b0;
    end
  end
  always_ff @(posedge refclk)
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q <= '0;
      idx_q <= '0;
      tmr_q <= '0;
      wr_q <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      err_q <= 1'b0;
      stale_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      tmr_q <= tmr_d;
      wr_q <= wr_d;
      addr_q <= addr_d;
      data_q <= data_d;
      busy_q <= busy_d;
      done_q <= done_d;
      err_q <= err_d;
      stale_q <= stale_d;
    end
  assign cfg_busy = busy_q;
  assign cfg_done = done_q;
  assign cfg_err = err_q;
  assign mgmt_write = wr_q;
  assign mgmt_address = addr_q;
  assign mgmt_writedata = data_q;
endmodule

// File: tb/tb_pll_reconfig_sequencer.sv
// tb_pll_reconfig_sequencer: directed checks of the PLL reconfig sequencer against an Avalon/PLL model
module tb_pll_reconfig_sequencer;
  localparam int LT = 60;
  localparam int BT = 32;
  logic        refclk = 1'b0;
  logic        rst, tbl_we, cfg_start, mgmt_waitrequest, pll_locked;
  logic [2:0]  tbl_idx;
  logic [5:0]  tbl_addr;
  logic [31:0] tbl_data;
  logic [3:0]  cfg_count;
  logic        cfg_busy, cfg_done, cfg_err, mgmt_write;
  logic [5:0]  mgmt_address;
  logic [31:0] mgmt_writedata;
  int          n_chk, n_bad, cyc, st_cyc, done_cnt, stall_left, lock_cnt, d0, lat;
  logic        stall_arm, hold, relock;
  logic [37:0] wlog[$];
  logic [37:0] exp_q[$];

  pll_reconfig_sequencer #(.DEPTH(8), .LOCK_TIMEOUT(LT), .BUSY_TIMEOUT(BT)) dut (
    .refclk(refclk), .rst(rst), .tbl_we(tbl_we), .tbl_idx(tbl_idx), .tbl_addr(tbl_addr),
    .tbl_data(tbl_data), .cfg_count(cfg_count), .cfg_start(cfg_start), .cfg_busy(cfg_busy),
    .cfg_done(cfg_done), .cfg_err(cfg_err), .mgmt_address(mgmt_address), .mgmt_write(mgmt_write),
    .mgmt_writedata(mgmt_writedata), .mgmt_waitrequest(mgmt_waitrequest), .pll_locked(pll_locked)
  );

  always #5 refclk = ~refclk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge refclk);
      #1;
    end
  endtask

  task automatic load(input int i, input logic [5:0] a, input logic [31:0] d);
    tbl_idx = 3'(i);
    tbl_addr = a;
    tbl_data = d;
    tbl_we = 1'b1;
    step();
    tbl_we = 1'b0;
  endtask

  task automatic start(input int c);
    cfg_count = 4'(c);
    cfg_start = 1'b1;
    step();
    cfg_start = 1'b0;
  endtask

  task automatic wait_for(input string tag, input int sel, input int bound);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < bound && !hit; i++) begin
      step();
      hit = sel == 0 ? cfg_done : sel == 1 ? cfg_err : (mgmt_write && mgmt_address == 6'h04);
    end
    check(tag, 64'(hit), 64'd1);
  endtask

  task automatic expect_w(input logic [5:0] a, input logic [31:0] d);
    exp_q.push_back({a, d});
  endtask

  task automatic expect_seq3();
    exp_q.delete();
    expect_w(6'h00, 32'h0);
    expect_w(6'h04, 32'h0000_0808);
    expect_w(6'h03, 32'h0001_0000);
    expect_w(6'h05, 32'h0002_0404);
    expect_w(6'h02, 32'h0);
  endtask

  task automatic check_log(input string tag);
    check({tag, "_len"}, 64'(wlog.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < wlog.size(); i++)
      check($sformatf("%s_w%0d", tag, i), 64'(wlog[i]), 64'(exp_q[i]));
  endtask

  // Avalon slave and PLL model: decide waitrequest for the coming edge, then log writes that complete on it
  initial begin
    mgmt_waitrequest = 1'b0;
    pll_locked = 1'b1;
    cyc = 0;
    st_cyc = 0;
    done_cnt = 0;
    stall_left = 0;
    lock_cnt = 0;
    forever begin
      @(negedge refclk);
      cyc++;
      if (cfg_done) done_cnt++;
      if (hold) mgmt_waitrequest = 1'b1;
      else if (stall_left > 0) begin
        check("stall_hold", 64'({mgmt_write, mgmt_address, mgmt_writedata}), 64'({1'b1, 6'h04, 32'h0000_0808}));
        stall_left--;
        mgmt_waitrequest = stall_left != 0;
      end else if (stall_arm && mgmt_write && mgmt_address == 6'h04) begin
        mgmt_waitrequest = 1'b1;
        stall_left = 5;
        stall_arm = 1'b0;
      end else mgmt_waitrequest = 1'b0;
      if (lock_cnt > 0) begin
        lock_cnt--;
        if (lock_cnt == 0) pll_locked = relock;
      end
      if (mgmt_write && !mgmt_waitrequest) begin
        wlog.push_back({mgmt_address, mgmt_writedata});
        if (mgmt_address == 6'h02) begin
          pll_locked = 1'b0;
          lock_cnt = 20;
          st_cyc = cyc;
        end
      end
    end
  end

  initial begin
    n_chk = 0;
    n_bad = 0;
    rst = 1'b1;
    tbl_we = 1'b0;
    cfg_start = 1'b0;
    tbl_idx = '0;
    tbl_addr = '0;
    tbl_data = '0;
    cfg_count = '0;
    stall_arm = 1'b0;
    hold = 1'b0;
    relock = 1'b1;
    step(3);
    rst = 1'b0;
    check("rst_out", 64'({cfg_busy, cfg_done, cfg_err, mgmt_write, mgmt_address, mgmt_writedata}), 64'd0);

    load(0, 6'h04, 32'h0000_0808);
    load(1, 6'h03, 32'h0001_0000);
    load(2, 6'h05, 32'h0002_0404);
    wlog.delete();
    d0 = done_cnt;
    start(3);
    check("busy_on", 64'(cfg_busy), 64'd1);
    wait_for("done1", 0, 300);
    step();
    expect_seq3();
    check_log("seq3");
    check("done1_cnt", 64'(done_cnt - d0), 64'd1);
    check("done1_busy", 64'(cfg_busy), 64'd0);
    check("done1_err", 64'(cfg_err), 64'd0);

    wlog.delete();
    stall_arm = 1'b1;
    d0 = done_cnt;
    start(3);
    step(2);
    load(1, 6'h3F, 32'hDEAD_BEEF);
    cfg_count = 4'd0;
    cfg_start = 1'b1;
    step();
    cfg_start = 1'b0;
    wait_for("done2", 0, 300);
    cfg_count = 4'd3;
    cfg_start = 1'b1;
    step();
    cfg_start = 1'b0;
    check("b2b_ignored", 64'(cfg_busy), 64'd0);
    check("stall_used", 64'(stall_arm), 64'd0);
    check_log("stall");
    check("done2_cnt", 64'(done_cnt - d0), 64'd1);

    wlog.delete();
    start(0);
    wait_for("done3", 0, 300);
    step();
    exp_q.delete();
    expect_w(6'h00, 32'h0);
    expect_w(6'h02, 32'h0);
    check_log("cnt0");

    for (int i = 3; i < 8; i++) load(i, 6'h10 + 6'(i), 32'(i) * 32'h11);
    wlog.delete();
    start(15);
    wait_for("done4", 0, 300);
    step();
    exp_q.delete();
    expect_w(6'h00, 32'h0);
    expect_w(6'h04, 32'h0000_0808);
    expect_w(6'h03, 32'h0001_0000);
    expect_w(6'h05, 32'h0002_0404);
    for (int i = 3; i < 8; i++) expect_w(6'h10 + 6'(i), 32'(i) * 32'h11);
    expect_w(6'h02, 32'h0);
    check_log("sat");

    wlog.delete();
    hold = 1'b1;
    d0 = done_cnt;
    start(0);
    wait_for("busy_tmo", 1, 200);
    check("busy_tmo_log", 64'(wlog.size()), 64'd0);
    check("busy_tmo_wr", 64'(mgmt_write), 64'd0);
    check("busy_tmo_busy", 64'(cfg_busy), 64'd0);
    hold = 1'b0;
    step();
    check("busy_tmo_nodone", 64'(done_cnt - d0), 64'd0);

    relock = 1'b0;
    d0 = done_cnt;
    start(0);
    check("err_clear", 64'(cfg_err), 64'd0);
    wait_for("lock_tmo", 1, 300);
    lat = cyc - st_cyc;
    check("lock_tmo_lat", 64'(lat >= LT && lat <= LT + 4), 64'd1);
    check("lock_tmo_busy", 64'(cfg_busy), 64'd0);
    step(3);
    check("lock_tmo_nodone", 64'(done_cnt - d0), 64'd0);
    check("lock_tmo_sticky", 64'(cfg_err), 64'd1);

    relock = 1'b1;
    start(3);
    wait_for("in_write", 2, 50);
    rst = 1'b1;
    step();
    check("rst_mid", 64'({cfg_busy, cfg_done, cfg_err, mgmt_write, mgmt_address, mgmt_writedata}), 64'd0);
    rst = 1'b0;
    step();
    wlog.delete();
    d0 = done_cnt;
    start(3);
    wait_for("done5", 0, 300);
    step();
    expect_seq3();
    check_log("after_rst");
    check("done5_cnt", 64'(done_cnt - d0), 64'd1);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
endmodule
